// File: rtl/cam_i2c_pkg.sv
// +--------------------------------------------------------------------------+
// | cam_i2c_pkg                                                              |
// | Shared state encoding, report geometry and report byte lookup.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package cam_i2c_pkg;

  localparam int         REPORT_LEN     = 16;
  localparam logic [6:0] DEF_DEV_ADDR   = 7'h58;
  localparam logic [7:0] DEF_REPORT_PTR = 8'h36;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_WR_BYTE  = 4'd3,
    ST_WR_ACK   = 4'd4,
    ST_RD_BYTE  = 4'd5,
    ST_RD_ACK   = 4'd6,
    ST_IGNORE   = 4'd7
  } cam_state_e;

  // snap = {y[9:8], x[9:8], size, y[7:0], x[7:0]}; bytes past 3 are padding.
  function automatic logic [7:0] report_byte(input logic [4:0]  idx,
                                             input logic        valid,
                                             input logic [23:0] snap);
    logic [7:0] b;
    b = 8'hFF;
    if (!valid) begin
      b = 8'h00;
    end else begin
      case (idx)
        5'd0:    b = 8'h00;
        5'd1:    b = snap[7:0];
        5'd2:    b = snap[15:8];
        5'd3:    b = snap[23:16];
        default: b = 8'hFF;
      endcase
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// +--------------------------------------------------------------------------+
// | i2c_line_sync                                                            |
// | Two-flop synchronizers for SCL/SDA plus edge, START and STOP detection.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  assign sda_level = r_sda_sync[1];
  assign scl_rise  =  r_scl_sync[1] & ~r_scl_d;
  assign scl_fall  = ~r_scl_sync[1] &  r_scl_d;
  assign start     =  r_scl_sync[1] &  r_scl_d & ~r_sda_sync[1] &  r_sda_d;
  assign stop      =  r_scl_sync[1] &  r_scl_d &  r_sda_sync[1] & ~r_sda_d;

endmodule

`default_nettype wire

// File: rtl/cam_i2c_responder.sv
// +--------------------------------------------------------------------------+
// | cam_i2c_responder                                                        |
// | I2C target: pointer/config writes and blob report reads.                 |
// | Optional macro CAM_TXN_COUNT_EN adds the txn_count output.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cam_i2c_responder
  import cam_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
  parameter logic [7:0] REPORT_PTR = DEF_REPORT_PTR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_out,
  output logic       i2c_sda_dir,
  input  logic [9:0] blob_x,
  input  logic [9:0] blob_y,
  input  logic [3:0] blob_size,
  output logic       cfg_wr,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       busy
`ifdef CAM_TXN_COUNT_EN
  ,
  output logic [7:0] txn_count
`endif
);

  logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  cam_state_e  r_state, w_state_nxt;
  logic        r_sda_dir, w_sda_dir_nxt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift, r_tx, r_pointer;
  logic        r_rw, r_ptr_loaded, r_busy, r_rd_valid;
  logic [4:0]  r_rd_cnt, w_rd_cnt_inc;
  logic [23:0] r_snap;
  logic        r_cfg_wr;
  logic [7:0]  r_cfg_addr, r_cfg_data;
  logic        w_byte_done, w_addr_match, w_addr_ack;
  logic [7:0]  w_rd_byte;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (i2c_scl),
    .sda       (i2c_sda_in),
    .sda_level (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start     (w_start),
    .stop      (w_stop)
  );

  assign w_byte_done  = (r_bit_cnt == 4'd8);
  assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
  assign w_addr_ack   = (r_state == ST_ADDR) && w_scl_fall && w_byte_done &&
                        w_addr_match && !w_start && !w_stop;
  assign w_rd_byte    = report_byte(r_rd_cnt, r_rd_valid, r_snap);
  assign w_rd_cnt_inc = (r_rd_cnt == 5'(REPORT_LEN)) ? r_rd_cnt : r_rd_cnt + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sda_dir <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sda_dir <= w_sda_dir_nxt;
    end
  end

  // SDA drive only ever changes on a detected SCL fall, START or STOP.
  always_comb begin
    w_state_nxt   = r_state;
    w_sda_dir_nxt = r_sda_dir;
    if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_sda_dir_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_sda_dir_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_fall && w_byte_done) begin
          w_state_nxt   = w_addr_match ? ST_ADDR_ACK : ST_IGNORE;
          w_sda_dir_nxt = w_addr_match;
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          w_state_nxt   = r_rw ? ST_RD_BYTE : ST_WR_BYTE;
          w_sda_dir_nxt = r_rw ? ~w_rd_byte[7] : 1'b0;
        end
        ST_WR_BYTE: if (w_scl_fall && w_byte_done) begin
          w_state_nxt   = ST_WR_ACK;
          w_sda_dir_nxt = 1'b1;
        end
        ST_WR_ACK: if (w_scl_fall) begin
          w_state_nxt   = ST_WR_BYTE;
          w_sda_dir_nxt = 1'b0;
        end
        ST_RD_BYTE: if (w_scl_fall) begin
          w_state_nxt   = w_byte_done ? ST_RD_ACK : ST_RD_BYTE;
          w_sda_dir_nxt = w_byte_done ? 1'b0 : ~r_tx[6];
        end
        ST_RD_ACK: if (w_scl_rise && w_sda) begin
          w_state_nxt   = ST_IGNORE;
          w_sda_dir_nxt = 1'b0;
        end else if (w_scl_fall) begin
          w_state_nxt   = ST_RD_BYTE;
          w_sda_dir_nxt = ~w_rd_byte[7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tx         <= '0;
      r_pointer    <= '0;
      r_rw         <= 1'b0;
      r_ptr_loaded <= 1'b0;
      r_busy       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_cnt     <= '0;
      r_snap       <= '0;
      r_cfg_wr     <= 1'b0;
      r_cfg_addr   <= '0;
      r_cfg_data   <= '0;
    end else begin
      r_cfg_wr <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_stop) begin
        r_busy <= 1'b0;
      end else begin
        if (w_scl_rise) begin
          r_shift   <= {r_shift[6:0], w_sda};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        case (r_state)
          ST_ADDR: if (w_scl_fall && w_byte_done) begin
            r_busy <= w_addr_match;
            if (w_addr_match) begin
              r_rw         <= r_shift[0];
              r_ptr_loaded <= 1'b0;
              if (r_shift[0]) begin
                r_snap     <= {blob_y[9:8], blob_x[9:8], blob_size, blob_y[7:0], blob_x[7:0]};
                r_rd_valid <= (r_pointer == REPORT_PTR);
                r_rd_cnt   <= '0;
              end
            end
          end
          ST_ADDR_ACK: if (w_scl_fall) begin
            r_bit_cnt <= '0;
            if (r_rw) begin
              r_tx     <= w_rd_byte;
              r_rd_cnt <= w_rd_cnt_inc;
            end
          end
          ST_WR_BYTE: if (w_scl_fall && w_byte_done) begin
            if (!r_ptr_loaded) begin
              r_pointer    <= r_shift;
              r_ptr_loaded <= 1'b1;
            end else begin
              r_cfg_wr   <= 1'b1;
              r_cfg_addr <= r_pointer;
              r_cfg_data <= r_shift;
              r_pointer  <= r_pointer + 8'd1;
            end
          end
          ST_WR_ACK: if (w_scl_fall) begin
            r_bit_cnt <= '0;
          end
          ST_RD_BYTE: if (w_scl_fall) begin
            r_tx <= {r_tx[6:0], 1'b1};
          end
          ST_RD_ACK: if (w_scl_rise && w_sda) begin
            r_busy <= 1'b0;
          end else if (w_scl_fall) begin
            r_tx      <= w_rd_byte;
            r_rd_cnt  <= w_rd_cnt_inc;
            r_bit_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CAM_TXN_COUNT_EN
  logic       r_txn_open;
  logic [7:0] r_txn_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txn_open  <= 1'b0;
      r_txn_count <= '0;
    end else if (w_stop) begin
      r_txn_open <= 1'b0;
      if (r_txn_open) r_txn_count <= r_txn_count + 8'd1;
    end else if (w_addr_ack) begin
      r_txn_open <= 1'b1;
    end
  end

  assign txn_count = r_txn_count;
`endif

  assign i2c_sda_out = 1'b0;
  assign i2c_sda_dir = r_sda_dir;
  assign busy        = r_busy;
  assign cfg_wr      = r_cfg_wr;
  assign cfg_addr    = r_cfg_addr;
  assign cfg_data    = r_cfg_data;

endmodule

`default_nettype wire
